// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared loader state encoding and memory geometry constants
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int IMEM_WORDS = 8;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - MSB-first byte-to-word shift register with running XOR checksum
module byte_packer
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    shift_en,
  input  logic [7:0]              byte_in,
  output logic [WORD_BYTES*8-1:0] word_next,
  output logic                    word_full,
  output logic [7:0]              csum
);

  localparam int W     = WORD_BYTES * 8;
  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     word_q, word_d;
  logic [7:0]       csum_q, csum_d;

  // word_full flags the shift that completes a word, so the caller can
  // capture word_next on that same edge.
  always_comb begin
    word_next = {word_q[W-9:0], byte_in};
    word_full = shift_en && (cnt_q == CNT_W'(WORD_BYTES - 1));
    cnt_d     = cnt_q;
    word_d    = word_q;
    csum_d    = csum_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
      csum_d = '0;
    end else if (shift_en) begin
      cnt_d  = cnt_q + 1'b1;
      word_d = word_next;
      csum_d = csum_q ^ byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a checksummed byte-stream image into instruction memory
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = IMEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        word_count
);

  state_e            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [3:0]        widx_q, widx_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              xfer;
  logic              pk_clear;
  logic              pk_shift;
  logic [DATA_W-1:0] pk_word_next;
  logic              pk_word_full;
  logic [7:0]        pk_csum;

  assign byte_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign xfer       = byte_valid && byte_ready;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (byte_data),
    .word_next (pk_word_next),
    .word_full (pk_word_full),
    .csum      (pk_csum)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    widx_d   = widx_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR;
          widx_d   = '0;
          wcnt_d   = '0;
          pk_clear = 1'b1;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          n_d = byte_data;
          if (byte_data == 8'd0 || byte_data > 8'(MAX_WORDS)) state_d = ST_ERR;
          else                                                 state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          pk_shift = 1'b1;
          // Address and data are registered here so they are stable for the whole WRITE cycle.
          if (pk_word_full) begin
            state_d = ST_WRITE;
            addr_d  = ADDR_W'(widx_q) * ADDR_W'(WORD_BYTES);
            wdata_d = pk_word_next;
          end
        end
      end
      ST_WRITE: begin
        widx_d = widx_q + 4'd1;
        wcnt_d = wcnt_q + 4'd1;
        if ({4'd0, widx_q} + 8'd1 == n_q) state_d = ST_CSUM;
        else                              state_d = ST_DATA;
      end
      ST_CSUM: begin
        if (xfer) state_d = (byte_data == pk_csum) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = (state_q != ST_DONE);
  assign busy       = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                      (state_q == ST_WRITE) || (state_q == ST_CSUM);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven frame loads with a write scoreboard for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_rst, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [3:0]  word_count;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] exp_q[$];
  logic [31:0] mem [8];

  typedef struct {
    int          n;
    logic [31:0] w [8];
    bit          use_cs;
    logic [7:0]  cs;
    bit          gaps;
    bit          poke;
    bit          exp_done;
    bit          exp_err;
    logic [3:0]  exp_wc;
  } row_t;

  row_t rows [6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input int n, input logic [31:0] w [8]);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) s ^= w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    return s;
  endfunction

  task automatic set_row(input int r, input int n, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input bit use_cs, input logic [7:0] cs,
                         input bit gaps, input bit poke, input bit ed, input bit ee);
    for (int i = 0; i < 8; i++) rows[r].w[i] = 32'h0;
    rows[r].n = n;
    rows[r].w[0] = w0;
    rows[r].w[1] = w1;
    rows[r].w[2] = w2;
    rows[r].use_cs = use_cs;
    rows[r].cs = cs;
    rows[r].gaps = gaps;
    rows[r].poke = poke;
    rows[r].exp_done = ed;
    rows[r].exp_err = ee;
    rows[r].exp_wc = 4'(n);
  endtask

  // Scoreboard: every write strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      checks++;
      if (byte_ready) begin
        errors++;
        $display("FAIL ready_in_write got=1 exp=0");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%h:%h exp=none", imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write got=%h:%h exp=%h:%h", imem_addr, imem_wdata, e[39:32], e[31:0]);
        end
      end
      mem[imem_addr[4:2]] = imem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit st);
    bit got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    start = st;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout got=0 exp=1");
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en && $urandom_range(1, 0) == 1) begin
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int r, output int lat);
    int          h;
    logic [31:0] wd;
    logic [7:0]  cs;
    pulse_start();
    send_byte(8'(rows[r].n), 1'b0);
    h = cyc;
    for (int wi = 0; wi < rows[r].n; wi++) begin
      wd = rows[r].w[wi];
      for (int bi = 0; bi < 4; bi++) begin
        gap(rows[r].gaps);
        if (bi == 3) exp_q.push_back({8'(wi * 4), wd});
        send_byte(8'(wd >> (8 * (3 - bi))), rows[r].poke && wi == 0 && bi == 2);
      end
    end
    cs = rows[r].use_cs ? rows[r].cs : xsum(rows[r].n, rows[r].w);
    gap(rows[r].gaps);
    send_byte(cs, 1'b0);
    lat = cyc - h;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    set_row(0, 2, 32'h00221820, 32'h00432020, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    set_row(1, 2, 32'h00221820, 32'h00432020, 32'h0, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 1'b1);
    set_row(2, 2, 32'h00221820, 32'h00432020, 32'h0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b1);
    set_row(3, 1, 32'h8C460005, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    set_row(4, 3, 32'h3C080010, 32'h25080004, 32'hAD090000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    set_row(5, 8, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rows[5].w[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", {cpu_rst, byte_ready, imem_we, busy, done, err}, 6'b100000);
    chk("reset_addr_data", {imem_addr, imem_wdata}, 40'h0);
    chk("reset_wcnt", word_count, 4'h0);

    byte_valid = 1'b1;
    byte_data = 8'h02;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignores_bytes", {byte_ready, busy}, 2'b00);
    end
    byte_valid = 1'b0;
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      run_frame(r, lat);
      @(negedge clk);
      chk($sformatf("row%0d_done", r), done, rows[r].exp_done);
      chk($sformatf("row%0d_err", r), err, rows[r].exp_err);
      chk($sformatf("row%0d_cpu_rst", r), cpu_rst, !rows[r].exp_done);
      chk($sformatf("row%0d_wcnt", r), word_count, rows[r].exp_wc);
      chk($sformatf("row%0d_busy", r), busy, 1'b0);
      if (!rows[r].gaps) chk($sformatf("row%0d_latency", r), lat, 5 * rows[r].n + 1);
      @(posedge clk);
      #1;
    end
    chk("full_depth_last_word", mem[7], rows[5].w[7]);

    pulse_start();
    @(negedge clk);
    chk("restart_from_done", {cpu_rst, busy, done}, 3'b110);
    @(posedge clk);
    #1;

    send_byte(8'd0, 1'b0);
    @(negedge clk);
    chk("hdr0_err", {err, busy, cpu_rst}, 3'b101);
    byte_valid = 1'b1;
    byte_data = 8'h01;
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", {err, byte_ready, busy}, 3'b100);
    end
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    pulse_start();
    send_byte(8'd9, 1'b0);
    @(negedge clk);
    chk("hdr9_err", {err, busy}, 2'b10);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    pulse_start();
    send_byte(8'd3, 1'b0);
    for (int bi = 0; bi < 6; bi++) begin
      logic [31:0] wd;
      wd = (bi < 4) ? rows[4].w[0] : rows[4].w[1];
      if (bi == 3) exp_q.push_back({8'h00, wd});
      send_byte(8'(wd >> (8 * (3 - (bi % 4)))), 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midload_reset_idle", {busy, done, err, cpu_rst, word_count}, 8'b0001_0000);
    chk("midload_word0_kept", mem[0], rows[4].w[0]);
    @(posedge clk);
    #1;
    run_frame(4, lat);
    @(negedge clk);
    chk("reload_done", {done, cpu_rst, word_count}, 6'b10_0011);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
